fft_sample_capture: RTL and testbench
=====================================

# fft_sample_capture

Acquisition front-end for the FFT spectrum path. It takes raw offset-binary ADC samples, decimates them, optionally waits for a level trigger, and converts each kept sample to two's complement. It writes one 256-point frame into the FFT input RAM through the `fft_data_in`/`fft_addr_in`/`fft_data_in_en` write port, then pulses `start` so the FFT stage begins its transform. It runs in the ADC clock domain, the same clock the FFT input RAM write port uses.

## Interface
Parameters:
- `ADC_WIDTH`, 8, ADC sample width (offset binary).
- `DATA_WIDTH`, 12, width of the FFT input sample (signed); must be ≥ `ADC_WIDTH`.
- `ADDR_WIDTH`, 8, FFT input RAM address width; frame length = 2^`ADDR_WIDTH`.
- `HOLDOFF`, 4096, clk cycles to wait after `start` before re-arming.
- `TIMEOUT`, 65535, kept samples to wait for a trigger before auto-capturing.

Ports:
- `clk` in 1: clock (ADC clock domain).
- `rst_n` in 1: reset, asynchronous, active-low; clock `clk`.
- `adc_data` in `ADC_WIDTH`: raw ADC sample.
- `adc_valid` in 1: `adc_data` valid this cycle.
- `decim` in 16: decimation ratio; 0 or 1 keeps every sample.
- `trig_en` in 1: 1 = wait for a rising level crossing; 0 = capture immediately.
- `trig_level` in `ADC_WIDTH`: trigger threshold, raw ADC units.
- `run` in 1: 1 = continuous frames; a rising edge starts one frame when idle.
- `fft_data_in` out `DATA_WIDTH` signed: converted sample.
- `fft_addr_in` out `ADDR_WIDTH`: write address.
- `fft_data_in_en` out 1: write strobe.
- `start` out 1: one-cycle pulse, frame complete.
- `busy` out 1: high in every state except IDLE.
- `trig_timeout` out 1: one-cycle pulse when a capture was forced by timeout.

## Operation
- **Conversion:** `fft_data_in = (adc_data − 2^(ADC_WIDTH−1)) << (DATA_WIDTH−ADC_WIDTH)`. With the default widths, 0x80→0, 0xFF→0x7F0, 0x00→0x800.
- **Decimation:**
  - Counter `dcnt` increments on each `adc_valid` and wraps at `max(decim,1)−1`.
  - A sample is "kept" when `adc_valid && dcnt==0`.
  - `dcnt` is cleared on entry to ARMED.
  - `decim` is sampled on entry to ARMED and held for the whole frame.
- **States:**
  - IDLE → ARMED on `run` rising edge, or if `run` is high on leaving HOLD.
  - ARMED:
    - With `trig_en=0`: go to CAPTURE immediately; the first kept sample becomes addr 0.
    - With `trig_en=1`: track the previous kept sample `prev`. Trigger when `prev < trig_level && cur ≥ trig_level`; the triggering sample is written as addr 0.
    - If `TIMEOUT` kept samples pass with no trigger: pulse `trig_timeout`, enter CAPTURE, and write the next kept sample as addr 0.
  - CAPTURE: each kept sample is written at addresses 1, 2, … . After writing addr 2^`ADDR_WIDTH`−1, go to START.
  - START: `start`=1 for one cycle → HOLD.
  - HOLD: count `HOLDOFF` cycles, then go to ARMED if `run`=1, else IDLE.
- **Boundaries:**
  - `run` falling mid-frame: the current frame completes, including `start`; the block then returns to IDLE.
  - `adc_valid` gaps: no write is issued and the address holds.
  - `trig_en` or `trig_level` changing while ARMED takes effect on the next kept sample.
  - The first kept sample after arming never triggers, because `prev` is invalid.
  - Reset mid-frame: the block returns to IDLE, no `start` is issued, and the partial frame is abandoned.

## Timing
- Reset values: all outputs 0; state IDLE.
- Write latency: a kept sample at cycle n produces `fft_data_in_en`=1 with data and address registered at cycle n+1.
- `fft_addr_in` increments by 1 per write and wraps to 0 only at the start of the next frame.
- `start` is asserted exactly one cycle after the write strobe for the last address.
- `busy` is low only in IDLE.
- `trig_timeout` pulse is asserted in the same cycle as the CAPTURE entry.

## Structure
- Package `fft_cap_pkg`:
  - state encoding (IDLE, ARMED, CAPTURE, START, HOLD);
  - `FRAME_LEN = 2**ADDR_WIDTH`;
  - conversion shift constant.
- Sub-module `fft_cap_decim`: decimation counter plus offset-to-signed conversion. It outputs a `kept` strobe and the converted sample. The top level holds the FSM, trigger detector, and address/holdoff counters.

## Test plan
- `trig_en=0`, `decim=1`, `run` pulse, ramp 0x00..0xFF continuous → 256 writes, addr 0..255, data 0x800…0x7F0 in steps of 0x10; `start` one cycle after the addr-255 write; then HOLD, then IDLE.
- `decim=4`, `adc_valid` always high → writes spaced 4 cycles apart, 256 writes, `start` after 1024 samples (±1).
- `trig_en=1`, `trig_level=0x80`, sine crossing upward → addr 0 data ≥ 0x000 with the previous sample < 0x80; no write before the crossing.
- `trig_en=1`, constant 0x40, `TIMEOUT`=16 (test override) → `trig_timeout` pulses after 16 kept samples; 256 writes of 0xC00 follow.
- `run` held high → HOLD of `HOLDOFF` cycles between frames, then a second frame. `run` dropped at addr 100 → the frame finishes, `start` fires, then IDLE.
- `rst_n` asserted at addr 50 → outputs 0 immediately, no `start`; after release, `busy`=0.

Source files
------------

// File: rtl/fft_cap_pkg.sv
// rtl/fft_cap_pkg.sv - shared types and constants for the FFT sample capture front-end
package fft_cap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_START,
      ST_HOLD
   } cap_state_t;

   function automatic int frame_len(input int addr_width);
      return 2 ** addr_width;
   endfunction

   function automatic int conv_shift(input int data_width, input int adc_width);
      return data_width - adc_width;
   endfunction

endpackage

// File: rtl/fft_cap_decim.sv
// rtl/fft_cap_decim.sv - decimation counter and offset-binary to two's complement conversion
module fft_cap_decim
   import fft_cap_pkg::*;
#(
   parameter int ADC_WIDTH  = 8,
   parameter int DATA_WIDTH = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic [15:0]                  decim,
   input  logic [ADC_WIDTH-1:0]         adc_data,
   input  logic                         adc_valid,
   output logic                         kept,
   output logic signed [DATA_WIDTH-1:0] sample
);

   localparam int SHIFT = conv_shift(DATA_WIDTH, ADC_WIDTH);

   logic [15:0]                  decim_q;
   logic [15:0]                  dcnt;
   logic [15:0]                  dlast;
   logic [ADC_WIDTH-1:0]         centered;
   logic signed [DATA_WIDTH-1:0] extended;

   assign dlast = (decim_q > 16'd1) ? decim_q - 16'd1 : 16'd0;
   assign kept  = adc_valid && (dcnt == 16'd0);

   // Subtracting mid-scale from offset binary is just an MSB flip.
   assign centered = {~adc_data[ADC_WIDTH-1], adc_data[ADC_WIDTH-2:0]};
   assign extended = DATA_WIDTH'(signed'(centered));
   assign sample   = extended <<< SHIFT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decim_q <= 16'd0;
         dcnt    <= 16'd0;
      end else if (clr) begin
         decim_q <= decim;
         dcnt    <= 16'd0;
      end else if (adc_valid) begin
         dcnt <= (dcnt >= dlast) ? 16'd0 : dcnt + 16'd1;
      end
   end

endmodule

// File: rtl/fft_sample_capture.sv
// rtl/fft_sample_capture.sv - decimate, trigger and write one frame into the FFT input RAM
module fft_sample_capture
   import fft_cap_pkg::*;
#(
   parameter int ADC_WIDTH  = 8,
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 8,
   parameter int HOLDOFF    = 4096,
   parameter int TIMEOUT    = 65535
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADC_WIDTH-1:0]         adc_data,
   input  logic                         adc_valid,
   input  logic [15:0]                  decim,
   input  logic                         trig_en,
   input  logic [ADC_WIDTH-1:0]         trig_level,
   input  logic                         run,
   output logic signed [DATA_WIDTH-1:0] fft_data_in,
   output logic [ADDR_WIDTH-1:0]        fft_addr_in,
   output logic                         fft_data_in_en,
   output logic                         start,
   output logic                         busy,
   output logic                         trig_timeout
);

   localparam int FRAME_LEN = frame_len(ADDR_WIDTH);
   localparam int HCW       = $clog2(HOLDOFF + 1);
   localparam int TCW       = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(FRAME_LEN - 1);
   localparam logic [HCW-1:0]        HOLD_LAST    = HCW'(HOLDOFF - 1);
   localparam logic [TCW-1:0]        TIMEOUT_LAST = TCW'(TIMEOUT - 1);

   cap_state_t                   state, state_nx;
   logic                         run_q;
   logic [ADDR_WIDTH-1:0]        widx, widx_nx;
   logic [HCW-1:0]               hcnt, hcnt_nx;
   logic [TCW-1:0]               tcnt, tcnt_nx;
   logic [ADC_WIDTH-1:0]         prev, prev_nx;
   logic                         prev_ok, prev_ok_nx;
   logic                         wr, to_pulse, start_nx, arm, trig_hit;
   logic                         kept;
   logic signed [DATA_WIDTH-1:0] sample;

   fft_cap_decim #(
      .ADC_WIDTH  (ADC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_decim (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (arm),
      .decim     (decim),
      .adc_data  (adc_data),
      .adc_valid (adc_valid),
      .kept      (kept),
      .sample    (sample)
   );

   // prev_ok keeps the first kept sample after arming from ever triggering.
   assign trig_hit = prev_ok && (prev < trig_level) && (adc_data >= trig_level);
   assign busy     = (state != ST_IDLE);

   always_comb begin
      state_nx   = state;
      widx_nx    = widx;
      hcnt_nx    = hcnt;
      tcnt_nx    = tcnt;
      prev_nx    = prev;
      prev_ok_nx = prev_ok;
      wr         = 1'b0;
      to_pulse   = 1'b0;
      start_nx   = 1'b0;
      arm        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (run && !run_q) state_nx = ST_ARMED;
         end
         ST_ARMED: begin
            if (kept) begin
               prev_nx    = adc_data;
               prev_ok_nx = 1'b1;
               if (!trig_en || trig_hit) begin
                  wr       = 1'b1;
                  widx_nx  = widx + 1'b1;
                  state_nx = ST_CAPTURE;
               end else if (tcnt == TIMEOUT_LAST) begin
                  to_pulse = 1'b1;
                  state_nx = ST_CAPTURE;
               end else begin
                  tcnt_nx = tcnt + 1'b1;
               end
            end
         end
         ST_CAPTURE: begin
            if (kept) begin
               wr      = 1'b1;
               widx_nx = widx + 1'b1;
               if (widx == LAST_ADDR) state_nx = ST_START;
            end
         end
         ST_START: begin
            start_nx = 1'b1;
            hcnt_nx  = '0;
            state_nx = ST_HOLD;
         end
         ST_HOLD: begin
            if (hcnt == HOLD_LAST) state_nx = run ? ST_ARMED : ST_IDLE;
            else                   hcnt_nx  = hcnt + 1'b1;
         end
         default: state_nx = ST_IDLE;
      endcase
      // Every frame starts from address 0 with fresh trigger history.
      if (state_nx == ST_ARMED && state != ST_ARMED) begin
         arm        = 1'b1;
         widx_nx    = '0;
         tcnt_nx    = '0;
         prev_ok_nx = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         run_q          <= 1'b0;
         widx           <= '0;
         hcnt           <= '0;
         tcnt           <= '0;
         prev           <= '0;
         prev_ok        <= 1'b0;
         fft_data_in    <= '0;
         fft_addr_in    <= '0;
         fft_data_in_en <= 1'b0;
         start          <= 1'b0;
         trig_timeout   <= 1'b0;
      end else begin
         state          <= state_nx;
         run_q          <= run;
         widx           <= widx_nx;
         hcnt           <= hcnt_nx;
         tcnt           <= tcnt_nx;
         prev           <= prev_nx;
         prev_ok        <= prev_ok_nx;
         fft_data_in_en <= wr;
         start          <= start_nx;
         trig_timeout   <= to_pulse;
         if (wr) begin
            fft_data_in <= sample;
            fft_addr_in <= widx;
         end
      end
   end

endmodule

// File: tb/tb_fft_sample_capture.sv
// tb/tb_fft_sample_capture.sv - directed self-checking bench for fft_sample_capture
module tb_fft_sample_capture;

   localparam int HOLDOFF = 20;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              rst_n;
   logic [7:0]        adc_data;
   logic              adc_valid;
   logic [15:0]       decim;
   logic              trig_en;
   logic [7:0]        trig_level;
   logic              run;
   logic signed [11:0] fft_data_in;
   logic [7:0]        fft_addr_in;
   logic              fft_data_in_en;
   logic              start;
   logic              busy;
   logic              trig_timeout;

   fft_sample_capture #(
      .ADC_WIDTH(8), .DATA_WIDTH(12), .ADDR_WIDTH(8), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid), .decim(decim),
      .trig_en(trig_en), .trig_level(trig_level), .run(run), .fft_data_in(fft_data_in),
      .fft_addr_in(fft_addr_in), .fft_data_in_en(fft_data_in_en), .start(start),
      .busy(busy), .trig_timeout(trig_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Source: 0 ramp, 1 constant 0x40, 2 trigger table then gappy ramp, 4 no data
   int src_mode = 4;
   int src_idx  = 0;
   logic [7:0] tbl [0:7] = '{8'hC0, 8'hA0, 8'h70, 8'h50, 8'h60, 8'h78, 8'h90, 8'hB0};

   always @(posedge clk) begin
      #1;
      case (src_mode)
         0: begin adc_valid = 1'b1; adc_data = src_idx[7:0]; end
         1: begin adc_valid = 1'b1; adc_data = 8'h40; end
         2: begin
            if (src_idx < 8) begin adc_valid = 1'b1; adc_data = tbl[src_idx]; end
            else begin adc_valid = (src_idx % 3 != 0); adc_data = src_idx[7:0]; end
         end
         default: begin adc_valid = 1'b0; adc_data = 8'h00; end
      endcase
      src_idx = src_idx + 1;
   end

   logic [11:0] wr_data [0:1023];
   logic [7:0]  wr_addr [0:1023];
   int          wr_cyc  [0:1023];
   int          start_cyc [0:3];
   int wr_cnt, start_cnt, to_cnt, to_cyc, arm_cyc, idle_cyc;
   logic arm_seen, busy_prev;

   always @(negedge clk) begin
      if (fft_data_in_en && wr_cnt < 1024) begin
         wr_data[wr_cnt] = fft_data_in;
         wr_addr[wr_cnt] = fft_addr_in;
         wr_cyc[wr_cnt]  = cyc;
         wr_cnt++;
      end
      if (start) begin
         if (start_cnt < 4) start_cyc[start_cnt] = cyc;
         start_cnt++;
      end
      if (trig_timeout) begin to_cnt++; to_cyc = cyc; end
      if (busy && !busy_prev && !arm_seen) begin arm_seen = 1'b1; arm_cyc = cyc; end
      if (!busy && busy_prev) idle_cyc = cyc;
      busy_prev = busy;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] conv(input int v);
      return 12'((v - 128) * 16);
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
   endtask

   task automatic clear_mon();
      wr_cnt = 0; start_cnt = 0; to_cnt = 0; to_cyc = 0;
      arm_cyc = 0; idle_cyc = 0; arm_seen = 1'b0;
   endtask

   task automatic begin_frame(input int mode, input logic hold_run);
      clear_mon();
      src_mode = mode;
      src_idx  = 0;
      run      = 1'b1;
      tick(1);
      if (!hold_run) run = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int k = 0;
      while (wr_cnt < n && k < budget) begin tick(1); k++; end
      chk("wait_writes", 32'(wr_cnt >= n), 1);
   endtask

   task automatic wait_start(input int n, input int budget);
      int k = 0;
      while (start_cnt < n && k < budget) begin tick(1); k++; end
      chk("wait_start", 32'(start_cnt >= n), 1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin tick(1); k++; end
      chk("wait_idle", 32'(busy), 0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_data"},  32'(fft_data_in), 0);
      chk({tag, "_addr"},  32'(fft_addr_in), 0);
      chk({tag, "_en"},    32'(fft_data_in_en), 0);
      chk({tag, "_start"}, 32'(start), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_to"},    32'(trig_timeout), 0);
   endtask

   int snap;

   initial begin
      rst_n = 1'b0; run = 1'b0; trig_en = 1'b0; trig_level = 8'h80; decim = 16'd1;
      adc_valid = 1'b0; adc_data = 8'h00;
      clear_mon();
      busy_prev = 1'b0;
      tick(3);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      tick(3);

      // Free-running ramp, every sample kept
      begin_frame(0, 1'b0);
      wait_start(1, 600);
      chk("t1_count", 32'(wr_cnt), 256);
      chk("t1_first_lat", 32'(wr_cyc[0] - arm_cyc), 1);
      chk("t1_d0", 32'(wr_data[0]), 32'h800);
      chk("t1_d128", 32'(wr_data[128]), 32'h000);
      chk("t1_d255", 32'(wr_data[255]), 32'h7F0);
      for (int i = 0; i < 256; i++) begin
         chk($sformatf("t1_addr%0d", i), 32'(wr_addr[i]), 32'(i));
         chk($sformatf("t1_data%0d", i), 32'(wr_data[i]), 32'(conv(i)));
      end
      chk("t1_start_after_last", 32'(start_cyc[0] - wr_cyc[255]), 1);
      wait_idle(100);
      chk("t1_hold_len", 32'(idle_cyc - start_cyc[0]), HOLDOFF);
      chk("t1_start_cnt", 32'(start_cnt), 1);

      // Decimate by 4
      decim = 16'd4;
      begin_frame(0, 1'b0);
      wait_start(1, 1200);
      decim = 16'd1;
      chk("t2_count", 32'(wr_cnt), 256);
      chk("t2_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 4);
      chk("t2_span", 32'(wr_cyc[255] - wr_cyc[0]), 1020);
      chk("t2_start", 32'(start_cyc[0] - wr_cyc[0]), 1021);
      for (int i = 0; i < 256; i++)
         chk($sformatf("t2_data%0d", i), 32'(wr_data[i]), 32'(conv((4 * i) % 256)));
      wait_idle(100);

      // Level trigger on an upward crossing, then gaps in adc_valid
      trig_en = 1'b1;
      begin_frame(2, 1'b0);
      wait_start(1, 1200);
      chk("t3_count", 32'(wr_cnt), 256);
      chk("t3_trig_cycle", 32'(wr_cyc[0] - arm_cyc), 7);
      chk("t3_d0", 32'(wr_data[0]), 32'h100);
      chk("t3_d1", 32'(wr_data[1]), 32'h300);
      chk("t3_no_timeout", 32'(to_cnt), 0);
      for (int i = 0; i < 256; i++)
         chk($sformatf("t3_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      wait_idle(100);

      // No crossing: capture forced after TIMEOUT kept samples
      begin_frame(1, 1'b0);
      wait_start(1, 600);
      chk("t4_to_cnt", 32'(to_cnt), 1);
      chk("t4_to_cycle", 32'(to_cyc - arm_cyc), TIMEOUT);
      chk("t4_first_write", 32'(wr_cyc[0] - to_cyc), 1);
      chk("t4_count", 32'(wr_cnt), 256);
      chk("t4_a0", 32'(wr_addr[0]), 0);
      chk("t4_d0", 32'(wr_data[0]), 32'hC00);
      chk("t4_d255", 32'(wr_data[255]), 32'hC00);
      wait_idle(100);
      trig_en = 1'b0;

      // Continuous run, dropped partway through the second frame
      begin_frame(0, 1'b1);
      wait_writes(356, 800);
      run = 1'b0;
      wait_start(2, 400);
      chk("t5_rearm_gap", 32'(wr_cyc[256] - start_cyc[0]), HOLDOFF + 1);
      chk("t5_a256", 32'(wr_addr[256]), 0);
      chk("t5_a511", 32'(wr_addr[511]), 255);
      chk("t5_start2", 32'(start_cyc[1] - wr_cyc[511]), 1);
      wait_idle(100);
      chk("t5_hold_len", 32'(idle_cyc - start_cyc[1]), HOLDOFF);
      tick(30);
      chk("t5_count", 32'(wr_cnt), 512);
      chk("t5_start_cnt", 32'(start_cnt), 2);
      chk("t5_busy", 32'(busy), 0);

      // Reset mid-frame
      begin_frame(0, 1'b0);
      wait_writes(51, 200);
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("t6_rst");
      snap = wr_cnt;
      tick(3);
      rst_n = 1'b1;
      tick(300);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_no_start", 32'(start_cnt), 0);
      chk("t6_no_writes", 32'(wr_cnt), 32'(snap));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
